multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have exactly one clock and one reset; reset is asynchronous and active-low.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 Opcode  in  7  instruction opcode from datapath instruction register, valid from DECODE onward.
REQ-005 Funct  in  4  {funct7[5], funct3} from instruction register.
REQ-006 Zero  in  1  ALU zero flag, valid during BRANCH.
REQ-007 mem_ready  in  1  memory completion handshake; 1 = current access done this cycle.
REQ-008 PCWrite, IRWrite, MemRead, MemWrite, MemtoReg, RegWrite  out  1 each  datapath strobes/selects.
REQ-009 ALUSrcA  out  1  0 = PC, 1 = rs1;  ALUSrcB  out  2  00 = rs2, 01 = const 4, 10 = immediate.
REQ-010 PCSource  out  1  0 = ALU result, 1 = ALUOut register (branch target).
REQ-011 Operation  out  4  ALU op: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB.
REQ-012 illegal  out  1  one-cycle pulse on unsupported opcode;  retire  out  1  one-cycle pulse per completed instruction.
REQ-013 state_o  out  4  current state encoding, for debug.

Function
REQ-014 Supported opcodes: R-type 0110011, load 0000011, store 0100011, beq 1100011; all others illegal.
REQ-015 States: FETCH, DECODE, EXEC_R, WB_R, ADDR, MEM_RD, WB_MEM, MEM_WR, BRANCH; Moore outputs decoded from state register only (plus latched Funct for Operation).
REQ-016 FETCH: MemRead=1, ALUSrcA=0, ALUSrcB=01, Operation=ADD; hold while mem_ready=0; when mem_ready=1 assert IRWrite and PCWrite (PCSource=0) in that cycle, go to DECODE.
REQ-017 DECODE: ALUSrcA=0, ALUSrcB=10, Operation=ADD (branch target into ALUOut); latch Funct; next = EXEC_R (R), ADDR (load/store), BRANCH (beq), else FETCH with illegal=1.
REQ-018 EXEC_R: ALUSrcA=1, ALUSrcB=00, Operation from latched Funct: 0000 ADD, 1000 SUB, 0111 AND, 0110 OR, any other value ADD; next WB_R.
REQ-019 WB_R: RegWrite=1, MemtoReg=0, retire=1; next FETCH.
REQ-020 ADDR: ALUSrcA=1, ALUSrcB=10, Operation=ADD; next MEM_RD (load) or MEM_WR (store).
REQ-021 MEM_RD: MemRead=1, hold until mem_ready=1, then WB_MEM;  WB_MEM: RegWrite=1, MemtoReg=1, retire=1, next FETCH.
REQ-022 MEM_WR: MemWrite=1, hold until mem_ready=1; retire=1 in the mem_ready cycle; next FETCH.
REQ-023 BRANCH: ALUSrcA=1, ALUSrcB=00, Operation=SUB, PCSource=1, PCWrite=Zero, retire=1; next FETCH.
REQ-024 Latency without stalls: R 4 cycles, load 5, store 4, beq 3; each mem_ready=0 cycle adds exactly one cycle.
REQ-025 MemRead and MemWrite SHALL never be 1 together; RegWrite and MemWrite never together.
REQ-026 Strobes not listed for a state are 0; select outputs not listed are 0.

Reset
REQ-027 rst_n low SHALL immediately force state FETCH and latched Funct 0000, independent of clk.
REQ-028 While rst_n low, all outputs SHALL be 0 (including MemRead, Operation 0000, state_o=FETCH code).
REQ-029 Reset asserted mid-instruction (including during a MEM_WR stall) abandons it with no retire pulse; first cycle after release is FETCH.

Structure
REQ-030 Shared package holds: opcode constants, ALU Operation codes, ALUSrcB select codes, state enum.
REQ-031 One sub-module alu_decode (latched Funct + mode -> Operation), combinational, reused from single-cycle design.

Verification
REQ-032 R-type: Opcode 0110011, Funct 1000, mem_ready=1 -> states FETCH,DECODE,EXEC_R,WB_R; Operation 0110 in EXEC_R; RegWrite and retire in 4th cycle.
REQ-033 Load with stalls: Opcode 0000011, mem_ready low 2 cycles in FETCH and 3 in MEM_RD -> 10 cycles total, MemtoReg=1 with RegWrite in WB_MEM.
REQ-034 beq: Opcode 1100011, Zero=1 -> PCWrite=1, PCSource=1 in BRANCH; repeat Zero=0 -> PCWrite=0; both 3 cycles.
REQ-035 Illegal: Opcode 1111111 -> illegal pulse in DECODE, no RegWrite/MemWrite, next state FETCH.
REQ-036 Reset mid-store: rst_n low during MEM_WR stall -> outputs 0 asynchronously, no retire, FETCH after release.
REQ-037 All scenarios: assertion that MemRead&MemWrite and RegWrite&MemWrite never occur.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle controller: opcodes, ALU codes,
// ALUSrcB selects, the state encoding and the control-word layout.
package multicycle_control_pkg;

  localparam int unsigned OPC_W   = 7;
  localparam int unsigned FUNCT_W = 4;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned ST_W    = 4;
  localparam int unsigned SRCB_W  = 2;

  localparam logic [OPC_W-1:0] OPC_RTYPE = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_LOAD  = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_BEQ   = 7'b1100011;

  localparam logic [OP_W-1:0] ALU_AND = 4'b0000;
  localparam logic [OP_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [OP_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [OP_W-1:0] ALU_SUB = 4'b0110;

  localparam logic [SRCB_W-1:0] SRCB_RS2  = 2'b00;
  localparam logic [SRCB_W-1:0] SRCB_FOUR = 2'b01;
  localparam logic [SRCB_W-1:0] SRCB_IMM  = 2'b10;

  // How the ALU operation is chosen in a given state.
  typedef enum logic [1:0] {
    ALU_MODE_NONE  = 2'd0,
    ALU_MODE_ADD   = 2'd1,
    ALU_MODE_SUB   = 2'd2,
    ALU_MODE_FUNCT = 2'd3
  } alu_mode_e;

  // FETCH is the all-zero code so state_o reads as FETCH while in reset.
  typedef enum logic [ST_W-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_R = 4'd2,
    S_WB_R   = 4'd3,
    S_ADDR   = 4'd4,
    S_MEM_RD = 4'd5,
    S_WB_MEM = 4'd6,
    S_MEM_WR = 4'd7,
    S_BRANCH = 4'd8
  } state_e;

  typedef struct packed {
    logic              pc_write;
    logic              ir_write;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
    logic              reg_write;
    logic              alu_src_a;
    logic [SRCB_W-1:0] alu_src_b;
    logic              pc_source;
    logic              illegal;
    logic              retire;
  } ctrl_t;

  function automatic logic is_mem_op(input logic [OPC_W-1:0] opc);
    return (opc == OPC_LOAD) || (opc == OPC_STORE);
  endfunction

endpackage

// File: rtl/multicycle_control_alu_decode.sv
// ALU operation decode shared with the single-cycle core: maps the state's
// ALU mode and the latched {funct7[5], funct3} to an Operation code.
module alu_decode
  import multicycle_control_pkg::*;
(
  input  logic [FUNCT_W-1:0] funct,
  input  alu_mode_e          mode,
  output logic [OP_W-1:0]    operation_c
);

  // Unknown R-type funct values fall back to ADD.
  always_comb begin
    operation_c = ALU_AND;
    case (mode)
      ALU_MODE_ADD: operation_c = ALU_ADD;
      ALU_MODE_SUB: operation_c = ALU_SUB;
      ALU_MODE_FUNCT: begin
        case (funct)
          4'b0000: operation_c = ALU_ADD;
          4'b1000: operation_c = ALU_SUB;
          4'b0111: operation_c = ALU_AND;
          4'b0110: operation_c = ALU_OR;
          default: operation_c = ALU_ADD;
        endcase
      end
      default: operation_c = ALU_AND;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RISC-V style control unit: Moore FSM over the instruction phases
// with mem_ready handshakes on the memory states.
module multicycle_control
  import multicycle_control_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OPC_W-1:0]   Opcode,
  input  logic [FUNCT_W-1:0] Funct,
  input  logic               Zero,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               IRWrite,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [SRCB_W-1:0]  ALUSrcB,
  output logic               PCSource,
  output logic [OP_W-1:0]    Operation,
  output logic               illegal,
  output logic               retire,
  output logic [ST_W-1:0]    state_o
);

  state_e               state_q;
  state_e               state_d;
  logic [FUNCT_W-1:0]   funct_q;
  ctrl_t                ctrl_c;
  alu_mode_e            alu_mode_c;
  logic [OP_W-1:0]      alu_op_c;

  // State register and Funct latch; Funct is captured while in DECODE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      funct_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        funct_q <= Funct;
      end
    end
  end

  // Next state and control word.
  always_comb begin
    state_d    = state_q;
    ctrl_c     = '0;
    alu_mode_c = ALU_MODE_NONE;
    case (state_q)
      S_FETCH: begin
        ctrl_c.mem_read  = 1'b1;
        ctrl_c.alu_src_b = SRCB_FOUR;
        alu_mode_c       = ALU_MODE_ADD;
        if (mem_ready) begin
          ctrl_c.ir_write = 1'b1;
          ctrl_c.pc_write = 1'b1;
          state_d         = S_DECODE;
        end
      end
      S_DECODE: begin
        // Speculatively form the branch target into ALUOut.
        ctrl_c.alu_src_b = SRCB_IMM;
        alu_mode_c       = ALU_MODE_ADD;
        if (Opcode == OPC_RTYPE) begin
          state_d = S_EXEC_R;
        end else if (is_mem_op(Opcode)) begin
          state_d = S_ADDR;
        end else if (Opcode == OPC_BEQ) begin
          state_d = S_BRANCH;
        end else begin
          ctrl_c.illegal = 1'b1;
          state_d        = S_FETCH;
        end
      end
      S_EXEC_R: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = SRCB_RS2;
        alu_mode_c       = ALU_MODE_FUNCT;
        state_d          = S_WB_R;
      end
      S_WB_R: begin
        ctrl_c.reg_write = 1'b1;
        ctrl_c.retire    = 1'b1;
        state_d          = S_FETCH;
      end
      S_ADDR: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = SRCB_IMM;
        alu_mode_c       = ALU_MODE_ADD;
        state_d          = (Opcode == OPC_LOAD) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        ctrl_c.mem_read = 1'b1;
        if (mem_ready) begin
          state_d = S_WB_MEM;
        end
      end
      S_WB_MEM: begin
        ctrl_c.reg_write  = 1'b1;
        ctrl_c.mem_to_reg = 1'b1;
        ctrl_c.retire     = 1'b1;
        state_d           = S_FETCH;
      end
      S_MEM_WR: begin
        ctrl_c.mem_write = 1'b1;
        if (mem_ready) begin
          ctrl_c.retire = 1'b1;
          state_d       = S_FETCH;
        end
      end
      S_BRANCH: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = SRCB_RS2;
        ctrl_c.pc_source = 1'b1;
        ctrl_c.pc_write  = Zero;
        ctrl_c.retire    = 1'b1;
        alu_mode_c       = ALU_MODE_SUB;
        state_d          = S_FETCH;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  alu_decode u_alu_decode (
    .funct       (funct_q),
    .mode        (alu_mode_c),
    .operation_c (alu_op_c)
  );

  // Outputs are forced low for the whole time rst_n is asserted, not just
  // from the next clock, so the datapath never sees a stray MemRead in reset.
  assign PCWrite   = rst_n & ctrl_c.pc_write;
  assign IRWrite   = rst_n & ctrl_c.ir_write;
  assign MemRead   = rst_n & ctrl_c.mem_read;
  assign MemWrite  = rst_n & ctrl_c.mem_write;
  assign MemtoReg  = rst_n & ctrl_c.mem_to_reg;
  assign RegWrite  = rst_n & ctrl_c.reg_write;
  assign ALUSrcA   = rst_n & ctrl_c.alu_src_a;
  assign ALUSrcB   = rst_n ? ctrl_c.alu_src_b : SRCB_RS2;
  assign PCSource  = rst_n & ctrl_c.pc_source;
  assign Operation = rst_n ? alu_op_c : ALU_AND;
  assign illegal   = rst_n & ctrl_c.illegal;
  assign retire    = rst_n & ctrl_c.retire;
  assign state_o   = ST_W'(state_q);

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: each instruction is expanded into
// its expected per-cycle output trace, then replayed and compared cycle by cycle.
module tb_multicycle_control;
  import multicycle_control_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [6:0] Opcode;
  logic [3:0] Funct;
  logic       Zero;
  logic       mem_ready;
  logic       PCWrite, IRWrite, MemRead, MemWrite, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       PCSource;
  logic [3:0] Operation;
  logic       illegal, retire;
  logic [3:0] state_o;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .IRWrite(IRWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .PCSource(PCSource), .Operation(Operation), .illegal(illegal),
    .retire(retire), .state_o(state_o)
  );

  typedef struct packed {
    logic       pcw, irw, mr, mw, m2r, rw, srca;
    logic [1:0] srcb;
    logic       pcs;
    logic [3:0] op;
    logic       ill, ret;
    logic [3:0] st;
  } outv_t;

  typedef struct packed {
    logic       mr;
    logic [6:0] opc;
    logic [3:0] fn;
    logic       z;
    outv_t      exp;
  } cyc_t;

  cyc_t  plan[$];
  outv_t exp_cur;
  logic  exp_valid;
  int    vectors;
  int    errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic outv_t dut_out();
    outv_t o;
    o = {PCWrite, IRWrite, MemRead, MemWrite, MemtoReg, RegWrite, ALUSrcA,
         ALUSrcB, PCSource, Operation, illegal, retire, state_o};
    return o;
  endfunction

  function automatic logic supported(input logic [6:0] opc);
    return opc == 7'b0110011 || opc == 7'b0000011 ||
           opc == 7'b0100011 || opc == 7'b1100011;
  endfunction

  function automatic logic [3:0] r_op(input logic [3:0] fn);
    case (fn)
      4'b1000: return 4'b0110;
      4'b0111: return 4'b0000;
      4'b0110: return 4'b0001;
      default: return 4'b0010;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic push(input logic mr, input logic [6:0] opc, input logic [3:0] fn,
                      input logic z, input outv_t o);
    cyc_t c;
    c.mr = mr; c.opc = opc; c.fn = fn; c.z = z; c.exp = o;
    plan.push_back(c);
  endtask

  // Expected trace of one instruction: fetch, decode, then the class-specific phases.
  task automatic plan_instr(input logic [6:0] opc, input logic [3:0] fn, input logic z,
                            input int fst, input int mst);
    outv_t o;
    o = '0; o.st = S_FETCH; o.mr = 1'b1; o.srcb = 2'b01; o.op = 4'b0010;
    repeat (fst) push(1'b0, 7'($urandom), 4'($urandom), 1'($urandom), o);
    o.irw = 1'b1; o.pcw = 1'b1;
    push(1'b1, 7'($urandom), 4'($urandom), 1'($urandom), o);
    o = '0; o.st = S_DECODE; o.srcb = 2'b10; o.op = 4'b0010; o.ill = !supported(opc);
    push(1'($urandom), opc, fn, 1'($urandom), o);
    if (opc == 7'b0110011) begin
      o = '0; o.st = S_EXEC_R; o.srca = 1'b1; o.op = r_op(fn);
      push(1'($urandom), opc, 4'($urandom), 1'($urandom), o);
      o = '0; o.st = S_WB_R; o.rw = 1'b1; o.ret = 1'b1;
      push(1'($urandom), opc, 4'($urandom), 1'($urandom), o);
    end else if (opc == 7'b0000011 || opc == 7'b0100011) begin
      o = '0; o.st = S_ADDR; o.srca = 1'b1; o.srcb = 2'b10; o.op = 4'b0010;
      push(1'($urandom), opc, 4'($urandom), 1'($urandom), o);
      if (opc == 7'b0000011) begin
        o = '0; o.st = S_MEM_RD; o.mr = 1'b1;
        repeat (mst) push(1'b0, opc, 4'($urandom), 1'($urandom), o);
        push(1'b1, opc, 4'($urandom), 1'($urandom), o);
        o = '0; o.st = S_WB_MEM; o.rw = 1'b1; o.m2r = 1'b1; o.ret = 1'b1;
        push(1'($urandom), opc, 4'($urandom), 1'($urandom), o);
      end else begin
        o = '0; o.st = S_MEM_WR; o.mw = 1'b1;
        repeat (mst) push(1'b0, opc, 4'($urandom), 1'($urandom), o);
        o.ret = 1'b1;
        push(1'b1, opc, 4'($urandom), 1'($urandom), o);
      end
    end else if (opc == 7'b1100011) begin
      o = '0; o.st = S_BRANCH; o.srca = 1'b1; o.op = 4'b0110; o.pcs = 1'b1;
      o.pcw = z; o.ret = 1'b1;
      push(1'($urandom), opc, 4'($urandom), z, o);
    end
  endtask

  // Replay up to n planned cycles; inputs change just after each rising edge.
  task automatic run_plan(input int n);
    cyc_t c;
    for (int i = 0; i < n && plan.size() > 0; i++) begin
      c = plan.pop_front();
      @(posedge clk);
      #1;
      mem_ready = c.mr; Opcode = c.opc; Funct = c.fn; Zero = c.z;
      exp_cur = c.exp; exp_valid = 1'b1;
    end
  endtask

  always @(negedge clk) begin
    if (exp_valid) begin
      vectors++;
      if (dut_out() !== exp_cur) begin
        errors++;
        $display("FAIL cycle_outputs t=%0t actual=%h required=%h", $time, dut_out(), exp_cur);
      end
    end
    assert (!(MemRead && MemWrite)) else begin
      errors++;
      $display("FAIL mutex_memrd_memwr t=%0t actual=1 required=0", $time);
    end
    assert (!(RegWrite && MemWrite)) else begin
      errors++;
      $display("FAIL mutex_regwr_memwr t=%0t actual=1 required=0", $time);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [6:0] opc;
    logic [3:0] fn;
    int         kind;
    vectors = 0; errors = 0; exp_valid = 1'b0; exp_cur = '0;
    rst_n = 1'b0; mem_ready = 1'b0; Opcode = '0; Funct = '0; Zero = 1'b0;
    #2;
    chk("reset_all_zero", 32'(dut_out()), 32'd0);
    #10;
    rst_n = 1'b1;
    #1;
    chk("release_state", 32'(state_o), 32'(S_FETCH));
    chk("release_memread", 32'(MemRead), 32'd1);

    // R-type SUB, no stalls.
    plan_instr(7'b0110011, 4'b1000, 1'b0, 0, 0);
    chk("model_r_len", 32'(plan.size()), 32'd4);
    chk("model_r_op", 32'(plan[2].exp.op), 32'h6);
    chk("model_r_wb", 32'({plan[3].exp.rw, plan[3].exp.ret}), 32'h3);
    run_plan(100);

    // Load with 2 fetch and 3 memory stalls.
    plan_instr(7'b0000011, 4'b0000, 1'b0, 2, 3);
    chk("model_ld_len", 32'(plan.size()), 32'd10);
    chk("model_ld_wb", 32'({plan[9].exp.m2r, plan[9].exp.rw}), 32'h3);
    run_plan(100);

    // beq taken and not taken.
    plan_instr(7'b1100011, 4'b0000, 1'b1, 0, 0);
    chk("model_beq_len", 32'(plan.size()), 32'd3);
    chk("model_beq_taken", 32'({plan[2].exp.pcw, plan[2].exp.pcs}), 32'h3);
    run_plan(100);
    plan_instr(7'b1100011, 4'b0000, 1'b0, 0, 0);
    chk("model_beq_nt", 32'({plan[2].exp.pcw, plan[2].exp.pcs}), 32'h1);
    run_plan(100);

    // Illegal opcode.
    plan_instr(7'b1111111, 4'b0000, 1'b0, 0, 0);
    chk("model_ill_len", 32'(plan.size()), 32'd2);
    chk("model_ill_flag", 32'(plan[1].exp.ill), 32'd1);
    run_plan(100);

    // Store interrupted by reset during a write stall.
    plan_instr(7'b0100011, 4'b0000, 1'b0, 0, 6);
    run_plan(5);
    @(negedge clk);
    #1;
    exp_valid = 1'b0;
    mem_ready = 1'b0;
    plan.delete();
    chk("pre_reset_state", 32'(state_o), 32'(S_MEM_WR));
    #1 rst_n = 1'b0;
    #1;
    chk("reset_async_zero", 32'(dut_out()), 32'd0);
    @(posedge clk);
    #1;
    chk("reset_hold_zero", 32'(dut_out()), 32'd0);
    #2 rst_n = 1'b1;
    #1;
    chk("post_reset_state", 32'(state_o), 32'(S_FETCH));
    chk("post_reset_memread", 32'(MemRead), 32'd1);
    chk("post_reset_noretire", 32'(retire), 32'd0);

    // Random instruction mix.
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 4);
      case (kind)
        0: opc = 7'b0110011;
        1: opc = 7'b0000011;
        2: opc = 7'b0100011;
        3: opc = 7'b1100011;
        default: begin
          opc = 7'($urandom);
          if (supported(opc)) opc = 7'b1111111;
        end
      endcase
      case ($urandom_range(0, 4))
        0: fn = 4'b0000;
        1: fn = 4'b1000;
        2: fn = 4'b0111;
        3: fn = 4'b0110;
        default: fn = 4'($urandom);
      endcase
      plan_instr(opc, fn, 1'($urandom),
                 ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3)),
                 ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3)));
      run_plan(100);
    end

    @(negedge clk);
    #1;
    exp_valid = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
